// File: rtl/dcache_resp_if.sv
// dcache_resp_if
//   Bundles the core-side request port, the backing-memory port and the
//   hit/miss statistics of the dcache_resp controller.
//   slave  : the cache controller (responds to the core, initiates to memory)
//   master : the environment (core + backing RAM)
// Ports (signals):
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_inval  core request
//   cpu_busy/cpu_ack/cpu_rdata                   core response
//   mem_req/mem_we/mem_addr/mem_wdata            memory request
//   mem_rdata/mem_ack                            memory response
//   hit_cnt/miss_cnt                             load statistics
interface dcache_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_inval;
  logic              cpu_busy;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_inval, mem_rdata, mem_ack,
    output cpu_busy, cpu_ack, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_inval, mem_rdata, mem_ack,
    input  cpu_busy, cpu_ack, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_resp.sv
// dcache_resp
//   Direct-mapped, write-through, no-write-allocate data cache with one-word
//   lines. Accepts word loads/stores from the core, serves load hits locally
//   and forwards load misses and every store to the backing RAM.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dcache_resp_if.slave (core port, memory port, statistics)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for cpu_req / cpu_inval; cpu_ack pulses here
// S_LOOKUP  | tag compare on the latched request, decide hit/miss/store
// S_MISS_RD | load miss: memory read outstanding, line filled on mem_ack
// S_WR_THRU | store: memory write outstanding, done on mem_ack
module dcache_resp #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_resp_if.slave bus
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WA_W  = ADDR_W - 2;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS_RD, S_WR_THRU} state_t;

  state_t            r_state;
  state_t            w_next;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  // Latched request; only the word address is kept since access is word-only.
  logic [WA_W-1:0]   r_waddr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;

  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [15:0]       r_hit_cnt;
  logic [15:0]       r_miss_cnt;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_inval;
  logic                  w_load_hit;
  logic                  w_load_miss;
  logic                  w_store;
  logic                  w_fill;
  logic                  w_wr_done;
  logic                  w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^bus.cpu_addr[1:0];

  assign w_idx = r_waddr[INDEX_BITS-1:0];
  assign w_tag = r_waddr[WA_W-1:INDEX_BITS];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!bus.cpu_inval && bus.cpu_req) w_next = S_LOOKUP;
      S_LOOKUP:  begin
        if (r_we)       w_next = S_WR_THRU;
        else if (w_hit) w_next = S_IDLE;
        else            w_next = S_MISS_RD;
      end
      S_MISS_RD: if (bus.mem_ack) w_next = S_IDLE;
      S_WR_THRU: if (bus.mem_ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output/strobe decode; mem_ack only matters in the two waiting states,
  // so a stray ack in IDLE (e.g. after a reset abandoned a transaction) is dropped.
  always_comb begin
    w_accept    = 1'b0;
    w_inval     = 1'b0;
    w_load_hit  = 1'b0;
    w_load_miss = 1'b0;
    w_store     = 1'b0;
    w_fill      = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_inval  = bus.cpu_inval;
        w_accept = bus.cpu_req && !bus.cpu_inval;
      end
      S_LOOKUP: begin
        w_store     = r_we;
        w_load_hit  = !r_we && w_hit;
        w_load_miss = !r_we && !w_hit;
      end
      S_MISS_RD: w_fill    = bus.mem_ack;
      S_WR_THRU: w_wr_done = bus.mem_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_waddr     <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_waddr <= bus.cpu_addr[ADDR_W-1:2];
        r_we    <= bus.cpu_we;
        r_wdata <= bus.cpu_wdata;
      end

      if (w_inval)     r_valid        <= '0;
      else if (w_fill) r_valid[w_idx] <= 1'b1;

      r_cpu_ack <= w_load_hit || w_fill || w_wr_done;

      if (w_load_hit)  r_cpu_rdata <= r_data[w_idx];
      else if (w_fill) r_cpu_rdata <= bus.mem_rdata;

      if (w_load_miss || w_store) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= w_store;
        r_mem_addr <= {r_waddr, 2'b00};
      end else if (w_fill || w_wr_done) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end

      if (w_store) r_mem_wdata <= r_wdata;

      if (w_load_hit && (r_hit_cnt != 16'hFFFF))   r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (w_load_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  // Tag/data storage needs no reset: the valid bits gate every use.
  // A store miss leaves the line untouched (no write-allocate).
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= bus.mem_rdata;
    end else if (w_store && w_hit) begin
      r_data[w_idx] <= r_wdata;
    end
  end

  assign bus.cpu_busy  = (r_state != S_IDLE);
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.miss_cnt  = r_miss_cnt;

endmodule

// File: doc/dcache_resp.md
Name: dcache_resp

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Acts as the responder to the core's load/store request port and as the initiator toward the backing data RAM.
- Sits between the core datapath (ALU address, rf_do1 store data, mem-to-reg mux) and the synthesized data memory.
- Replaces the direct core-to-RAM connection with a handshake and stall signal, so that memories with multi-cycle latency are supported.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- INDEX_BITS, 4, log2 of the line count (16 one-word lines). Index is addr[INDEX_BITS+1:2]; tag is addr[ADDR_W-1:INDEX_BITS+2].

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored (word access only).
- cpu_wdata  in  DATA_W  store data.
- cpu_inval  in  1  invalidate all lines; sampled only in IDLE.
- cpu_busy  out  1  high whenever state != IDLE.
- cpu_ack  out  1  one-cycle registered pulse on completion of a request.
- cpu_rdata  out  DATA_W  load data; valid while cpu_ack=1, holds last value otherwise.
- mem_req  out  1  backing memory request; held until acknowledged.
- mem_we  out  1  backing memory write enable.
- mem_addr  out  ADDR_W  word-aligned address; [1:0]=0.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse from memory.
- hit_cnt  out  16  saturating count of load hits.
- miss_cnt  out  16  saturating count of load misses.

Behaviour:

Reset (async, any state, including mid-transaction):
- State → IDLE.
- All valid bits cleared.
- cpu_ack=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- hit_cnt=0, miss_cnt=0.
- A pending memory transaction is abandoned; a later mem_ack arriving in IDLE is ignored.

State machine (states: IDLE, LOOKUP, MISS_RD, WR_THRU):
- IDLE
  - If cpu_inval: clear all valid bits at this edge; stay IDLE; no ack. cpu_inval has priority over a simultaneous cpu_req, which is dropped (the core must re-present it).
  - Else if cpu_req: latch addr, we, wdata; → LOOKUP.
- LOOKUP
  - hit = valid[idx] & (tag[idx] == latched tag).
  - Load hit: cpu_rdata ← data[idx]; cpu_ack=1 next cycle; hit_cnt+1; → IDLE.
  - Load miss: mem_req←1, mem_we←0, mem_addr←latched addr; miss_cnt+1; → MISS_RD.
  - Store (hit or miss): if hit, data[idx] ← wdata; on a miss the line is untouched. Then mem_req←1, mem_we←1, mem_addr, mem_wdata ← latched values; → WR_THRU.
- MISS_RD
  - Hold mem_req and address stable until mem_ack sampled high.
  - On ack: data[idx]←mem_rdata, tag[idx]←tag, valid[idx]←1; cpu_rdata←mem_rdata; cpu_ack=1 next cycle; mem_req←0; → IDLE.
- WR_THRU
  - Hold mem_req/we/addr/wdata until mem_ack.
  - On ack: mem_req←0, mem_we←0; cpu_ack=1 next cycle; → IDLE.

Timing:
- Load hit latency: req sampled at edge E0, ack high in the cycle after E1 (2 edges).
- Miss latency: 2 edges plus memory wait.
- cpu_ack coincides with the IDLE state, so a new cpu_req in the ack cycle is accepted (back-to-back throughput: 1 request per 2 cycles on hits).
- mem_ack while mem_req=0 is ignored.
- cpu_req outside IDLE is ignored; the core holds its request while cpu_busy=1.

Boundary conditions:
- Counters saturate at 16'hFFFF, no wrap.
- Two addresses with the same index and different tag evict each other on load miss fill.
- A store to a resident line updates the cached copy and memory; a subsequent load hits with the new data.
- Invalidate clears all lines in a single cycle.

Test Plan:
1. Reset, load 0x0000_0040 (mem returns 0xDEADBEEF after 3 cycles) → mem_req held 3 cycles; cpu_ack with cpu_rdata=0xDEADBEEF; miss_cnt=1. Repeat load → ack 2 edges after req with no mem_req; hit_cnt=1.
2. Store 0x0000_0040 ← 0x12345678 with line resident → mem_req/mem_we high with mem_addr=0x40, mem_wdata=0x12345678 until ack. Following load → hit returning 0x12345678, no mem traffic.
3. Store to 0x0000_0080 (not resident), then load 0x80 → store causes no allocation; load misses (miss_cnt increments).
4. Load 0x40, then load 0x440 (same index, different tag), then load 0x40 → three misses; the final access misses due to eviction.
5. Assert cpu_inval and cpu_req together in IDLE → no ack, all lines invalid; next load of 0x40 misses.
6. Assert rst while in MISS_RD with mem_req=1, then pulse mem_ack one cycle after rst deasserts → outputs at reset values, ack ignored, state IDLE, counters 0.
